// File: rtl/tachyon_rf_pkg.sv
// Shared register-file constants, types and the write-back request record.
package tachyon_rf_pkg;

   localparam int SIZE        = 32;
   localparam int ADDR_WIDTH  = 5;
   localparam int REG_WIDTH   = 64;
   localparam int NR_RD_PORTS = 3;

   typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
   typedef logic [REG_WIDTH-1:0]  rf_val_t;

   typedef struct packed {
      rf_addr_t addr;
      rf_val_t  val;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module RrArbiter #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] cand;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand = PW'((32'(ptr) + off) % N);
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter with registered RF write port and per-register busy scoreboard.
// Optional forwarding from the output stage: define TACHYON_RF_WB_BYPASS_EN.
module rf_wb_arbiter
   import tachyon_rf_pkg::*;
#(
   parameter int NR_REQ = 3,
   parameter int NR_CHK = NR_RD_PORTS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NR_REQ-1:0]     req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr [NR_REQ],
   input  logic [REG_WIDTH-1:0]  req_val  [NR_REQ],
   output logic [NR_REQ-1:0]     req_ready,
   output logic                  rf_wr_enable,
   output logic [ADDR_WIDTH-1:0] rf_wr_addr,
   output logic [REG_WIDTH-1:0]  rf_wr_val,
   input  logic                  sb_set_valid,
   input  logic [ADDR_WIDTH-1:0] sb_set_addr,
   input  logic [ADDR_WIDTH-1:0] chk_addr [NR_CHK],
   output logic [NR_CHK-1:0]     chk_busy,
   output logic [SIZE-1:0]       sb_busy
`ifdef TACHYON_RF_WB_BYPASS_EN
   ,
   output logic [NR_CHK-1:0]     byp_hit,
   output logic [REG_WIDTH-1:0]  byp_val [NR_CHK]
`endif
);

   localparam int PW = $clog2(NR_REQ);

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     grant_idx;
   logic [NR_REQ-1:0] grant;
   logic              transfer;
   wb_req_t           reqs [NR_REQ];
   wb_req_t           win;
   logic [SIZE-1:0]   sb_next;

   for (genvar i = 0; i < NR_REQ; i++) begin : g_req
      assign reqs[i] = '{addr: req_addr[i], val: req_val[i]};
   end

   RrArbiter #(.N(NR_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grants are suppressed while reset is held so no requester sees a phantom transfer.
   assign req_ready = rst_n ? grant : '0;
   assign transfer  = |req_ready;
   assign win       = reqs[grant_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (transfer) begin
         rr_ptr <= (grant_idx == PW'(NR_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Writes to r0 are accepted but never reach the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr_enable <= 1'b0;
         rf_wr_addr   <= '0;
         rf_wr_val    <= '0;
      end else if (transfer) begin
         rf_wr_enable <= (win.addr != '0);
         rf_wr_addr   <= win.addr;
         rf_wr_val    <= win.val;
      end else begin
         rf_wr_enable <= 1'b0;
      end
   end

   // Set is applied after clear so a same-edge set/clear leaves the bit busy.
   always_comb begin
      sb_next = sb_busy;
      if (rf_wr_enable) begin
         sb_next[rf_wr_addr] = 1'b0;
      end
      if (sb_set_valid && (sb_set_addr != '0)) begin
         sb_next[sb_set_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_busy <= '0;
      end else begin
         sb_busy <= sb_next;
      end
   end

   for (genvar k = 0; k < NR_CHK; k++) begin : g_chk
`ifdef TACHYON_RF_WB_BYPASS_EN
      assign byp_hit[k]  = rf_wr_enable && (rf_wr_addr == chk_addr[k]) && (chk_addr[k] != '0);
      assign byp_val[k]  = rf_wr_val;
      assign chk_busy[k] = sb_busy[chk_addr[k]] && !byp_hit[k];
`else
      assign chk_busy[k] = sb_busy[chk_addr[k]];
`endif
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (bypass checks under TACHYON_RF_WB_BYPASS_EN).
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [4:0]  req_addr [3];
   logic [63:0] req_val  [3];
   logic [2:0]  req_ready;
   logic        rf_wr_enable;
   logic [4:0]  rf_wr_addr;
   logic [63:0] rf_wr_val;
   logic        sb_set_valid;
   logic [4:0]  sb_set_addr;
   logic [4:0]  chk_addr [3];
   logic [2:0]  chk_busy;
   logic [31:0] sb_busy;
`ifdef TACHYON_RF_WB_BYPASS_EN
   logic [2:0]  byp_hit;
   logic [63:0] byp_val [3];
`endif

   int tests;
   int fails;

   rf_wb_arbiter #(.NR_REQ(3), .NR_CHK(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_val      (req_val),
      .req_ready    (req_ready),
      .rf_wr_enable (rf_wr_enable),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_val    (rf_wr_val),
      .sb_set_valid (sb_set_valid),
      .sb_set_addr  (sb_set_addr),
      .chk_addr     (chk_addr),
      .chk_busy     (chk_busy),
      .sb_busy      (sb_busy)
`ifdef TACHYON_RF_WB_BYPASS_EN
      ,
      .byp_hit      (byp_hit),
      .byp_val      (byp_val)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      req_valid   = 3'b111;
      req_addr[0] = 5'd1;
      req_addr[1] = 5'd2;
      req_addr[2] = 5'd3;
      repeat (2) step();
      tests++;
      if (req_ready !== 3'b000) begin
         fails++; $display("FAIL reset_ready: got %b expected %b", req_ready, 3'b000);
      end
      tests++;
      if (rf_wr_enable !== 1'b0) begin
         fails++; $display("FAIL reset_wr_enable: got %b expected 0", rf_wr_enable);
      end
      tests++;
      if (rf_wr_addr !== 5'd0 || rf_wr_val !== 64'd0) begin
         fails++; $display("FAIL reset_wr_addr_val: got %h/%h expected 0/0", rf_wr_addr, rf_wr_val);
      end
      tests++;
      if (sb_busy !== 32'd0) begin
         fails++; $display("FAIL reset_sb_busy: got %h expected 0", sb_busy);
      end
      tests++;
      if (chk_busy !== 3'b000) begin
         fails++; $display("FAIL reset_chk_busy: got %b expected 000", chk_busy);
      end
      req_valid = 3'b000;
      rst_n     = 1'b1;
      step();
      tests++;
      if (rf_wr_enable !== 1'b0) begin
         fails++; $display("FAIL idle_wr_enable: got %b expected 0", rf_wr_enable);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rdy;
      req_val[0] = 64'hA0;
      req_val[1] = 64'hA1;
      req_val[2] = 64'hA2;
      req_valid  = 3'b111;
      #1;
      for (int c = 0; c < 6; c++) begin
         exp_rdy = 3'b001 << (c % 3);
         tests++;
         if (req_ready !== exp_rdy) begin
            fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_rdy);
         end
         step();
         tests++;
         if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'(c % 3 + 1)) begin
            fails++; $display("FAIL rr_wr[%0d]: got en=%b addr=%0d expected en=1 addr=%0d",
                              c, rf_wr_enable, rf_wr_addr, c % 3 + 1);
         end
         tests++;
         if (rf_wr_val !== 64'hA0 + 64'(c % 3)) begin
            fails++; $display("FAIL rr_val[%0d]: got %h expected %h", c, rf_wr_val, 64'hA0 + 64'(c % 3));
         end
      end
      req_valid = 3'b000;
      step();
      tests++;
      if (rf_wr_enable !== 1'b0) begin
         fails++; $display("FAIL rr_idle: got %b expected 0", rf_wr_enable);
      end
   endtask

   task automatic test_addr_zero();
      req_valid   = 3'b001;
      req_addr[0] = 5'd0;
      req_val[0]  = 64'h55;
      #1;
      tests++;
      if (req_ready !== 3'b001) begin
         fails++; $display("FAIL r0_ready: got %b expected 001", req_ready);
      end
      step();
      req_valid = 3'b000;
      tests++;
      if (rf_wr_enable !== 1'b0) begin
         fails++; $display("FAIL r0_wr_enable: got %b expected 0", rf_wr_enable);
      end
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd0;
      step();
      sb_set_valid = 1'b0;
      chk_addr[0]  = 5'd0;
      #1;
      tests++;
      if (sb_busy !== 32'd0) begin
         fails++; $display("FAIL r0_sb_busy: got %h expected 0", sb_busy);
      end
      tests++;
      if (chk_busy[0] !== 1'b0) begin
         fails++; $display("FAIL r0_chk_busy: got %b expected 0", chk_busy[0]);
      end
   endtask

   task automatic test_scoreboard();
      logic exp_busy;
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd7;
      step();
      sb_set_valid = 1'b0;
      chk_addr[1]  = 5'd7;
      #1;
      tests++;
      if (sb_busy !== 32'h0000_0080 || chk_busy[1] !== 1'b1) begin
         fails++; $display("FAIL sb_set7: got sb=%h chk=%b expected sb=00000080 chk=1", sb_busy, chk_busy[1]);
      end
      req_valid   = 3'b100;
      req_addr[2] = 5'd7;
      req_val[2]  = 64'hDEAD;
      #1;
      tests++;
      if (req_ready !== 3'b100 || chk_busy[1] !== 1'b1) begin
         fails++; $display("FAIL sb_grant7: got rdy=%b chk=%b expected rdy=100 chk=1", req_ready, chk_busy[1]);
      end
      step();
      req_valid = 3'b000;
`ifdef TACHYON_RF_WB_BYPASS_EN
      exp_busy = 1'b0;
`else
      exp_busy = 1'b1;
`endif
      #1;
      tests++;
      if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_val !== 64'hDEAD) begin
         fails++; $display("FAIL sb_wr7: got en=%b addr=%0d val=%h expected en=1 addr=7 val=dead",
                           rf_wr_enable, rf_wr_addr, rf_wr_val);
      end
      tests++;
      if (chk_busy[1] !== exp_busy || sb_busy[7] !== 1'b1) begin
         fails++; $display("FAIL sb_pending7: got chk=%b sb7=%b expected chk=%b sb7=1", chk_busy[1], sb_busy[7], exp_busy);
      end
      step();
      tests++;
      if (chk_busy[1] !== 1'b0 || sb_busy !== 32'd0) begin
         fails++; $display("FAIL sb_clear7: got chk=%b sb=%h expected chk=0 sb=0", chk_busy[1], sb_busy);
      end
   endtask

   task automatic test_set_clear_same();
      req_valid   = 3'b001;
      req_addr[0] = 5'd5;
      req_val[0]  = 64'h5;
      step();
      req_valid    = 3'b000;
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd5;
      #1;
      tests++;
      if (rf_wr_enable !== 1'b1 || rf_wr_addr !== 5'd5) begin
         fails++; $display("FAIL sc_wr5: got en=%b addr=%0d expected en=1 addr=5", rf_wr_enable, rf_wr_addr);
      end
      step();
      sb_set_valid = 1'b0;
      tests++;
      if (sb_busy !== 32'h0000_0020) begin
         fails++; $display("FAIL sc_set_wins: got %h expected 00000020", sb_busy);
      end
      req_valid   = 3'b010;
      req_addr[1] = 5'd5;
      step();
      req_valid = 3'b000;
      step();
      tests++;
      if (sb_busy !== 32'd0) begin
         fails++; $display("FAIL sc_cleanup: got %h expected 0", sb_busy);
      end
   endtask

`ifdef TACHYON_RF_WB_BYPASS_EN
   task automatic test_bypass();
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd9;
      step();
      sb_set_valid = 1'b0;
      chk_addr[0]  = 5'd0;
      chk_addr[2]  = 5'd9;
      req_valid    = 3'b010;
      req_addr[1]  = 5'd9;
      req_val[1]   = 64'h1234;
      #1;
      tests++;
      if (chk_busy[2] !== 1'b1 || byp_hit[2] !== 1'b0) begin
         fails++; $display("FAIL byp_before: got chk=%b hit=%b expected chk=1 hit=0", chk_busy[2], byp_hit[2]);
      end
      step();
      req_valid = 3'b000;
      #1;
      tests++;
      if (byp_hit[2] !== 1'b1 || byp_val[2] !== 64'h1234 || chk_busy[2] !== 1'b0) begin
         fails++; $display("FAIL byp_hit9: got hit=%b val=%h chk=%b expected hit=1 val=1234 chk=0",
                           byp_hit[2], byp_val[2], chk_busy[2]);
      end
      tests++;
      if (byp_hit[0] !== 1'b0) begin
         fails++; $display("FAIL byp_r0: got %b expected 0", byp_hit[0]);
      end
      step();
      tests++;
      if (byp_hit[2] !== 1'b0 || chk_busy[2] !== 1'b0) begin
         fails++; $display("FAIL byp_after: got hit=%b chk=%b expected 0/0", byp_hit[2], chk_busy[2]);
      end
   endtask
`endif

   task automatic test_reset_mid();
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd11;
      req_valid    = 3'b010;
      req_addr[1]  = 5'd11;
      req_val[1]   = 64'hBEEF;
      step();
      sb_set_valid = 1'b0;
      tests++;
      if (rf_wr_enable !== 1'b1 || sb_busy[11] !== 1'b1) begin
         fails++; $display("FAIL mid_setup: got en=%b sb11=%b expected 1/1", rf_wr_enable, sb_busy[11]);
      end
      req_valid = 3'b111;
      rst_n     = 1'b0;
      #1;
      tests++;
      if (rf_wr_enable !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_val !== 64'd0) begin
         fails++; $display("FAIL mid_outputs: got en=%b addr=%0d val=%h expected 0/0/0", rf_wr_enable, rf_wr_addr, rf_wr_val);
      end
      tests++;
      if (sb_busy !== 32'd0 || req_ready !== 3'b000 || chk_busy !== 3'b000) begin
         fails++; $display("FAIL mid_state: got sb=%h rdy=%b chk=%b expected 0/000/000", sb_busy, req_ready, chk_busy);
      end
      step();
      rst_n = 1'b1;
      #1;
      tests++;
      if (req_ready !== 3'b001) begin
         fails++; $display("FAIL mid_ptr_reset: got %b expected 001", req_ready);
      end
      req_valid = 3'b000;
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      rst_n        = 1'b0;
      req_valid    = 3'b000;
      sb_set_valid = 1'b0;
      sb_set_addr  = 5'd0;
      for (int i = 0; i < 3; i++) begin
         req_addr[i] = 5'd0;
         req_val[i]  = 64'd0;
         chk_addr[i] = 5'd0;
      end
      test_reset();
      test_round_robin();
      test_addr_zero();
      test_scoreboard();
      test_set_clear_same();
`ifdef TACHYON_RF_WB_BYPASS_EN
      test_bypass();
`endif
      test_reset_mid();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32 x 64-bit register file: shares the file's single write port among several write-back requesters (ALU, load unit, mul/div), using round-robin arbitration with a registered output stage. Also keeps a per-register busy scoreboard for issue-stage hazard checks on the three read addresses. Sits between the execution units and the register file write port, next to the issue logic.

## Interface
- NR_REQ, 3, number of write-back requesters (2..8)
- SIZE, 32, number of architectural registers (from package)
- ADDR_WIDTH, 5, register address width (from package)
- REG_WIDTH, 64, register data width (from package)
- NR_CHK, 3, number of hazard-check ports (matches register file read ports)

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid[NR_REQ]  in  1  requester i has a write-back
- req_addr[NR_REQ]  in  ADDR_WIDTH  destination register
- req_val[NR_REQ]  in  REG_WIDTH  write data
- req_ready[NR_REQ]  out  1  requester i granted this cycle (transfer = valid & ready)
- rf_wr_enable  out  1  register file write enable (registered)
- rf_wr_addr  out  ADDR_WIDTH  register file write address (registered)
- rf_wr_val  out  REG_WIDTH  register file write data (registered)
- sb_set_valid  in  1  issue marks a destination busy
- sb_set_addr  in  ADDR_WIDTH  destination being marked
- chk_addr[NR_CHK]  in  ADDR_WIDTH  source addresses to check
- chk_busy[NR_CHK]  out  1  source has a pending write (combinational)
- sb_busy  out  SIZE  raw scoreboard vector

## Operation
- Arbitration: round-robin over valid requesters, starting at pointer `rr_ptr`; at most one req_ready high per cycle; req_ready[i] never high without req_valid[i].
- After a transfer by requester g, rr_ptr <= (g+1) mod NR_REQ. rr_ptr is unchanged when there is no transfer.
- A transfer loads the output stage: rf_wr_enable <= 1, rf_wr_addr <= req_addr[g], rf_wr_val <= req_val[g]. With no transfer, rf_wr_enable <= 0; addr and val hold their values.
- Address 0 is hardwired zero:
  - A transfer to address 0 is accepted (ready asserted), but rf_wr_enable stays 0.
  - sb_set to address 0 is ignored.
  - chk_busy for address 0 is always 0.
- Scoreboard:
  - Bit a sets at the edge where sb_set_valid & sb_set_addr==a.
  - Bit a clears at the edge where rf_wr_enable & rf_wr_addr==a.
  - Set and clear of the same address at the same edge: set wins.
- chk_busy[k] = sb_busy[chk_addr[k]].
- The output stage has no back-pressure. The register file accepts a write every cycle.

## Timing
- Reset values: rf_wr_enable 0, rf_wr_addr 0, rf_wr_val 0, sb_busy all 0, rr_ptr 0. While rst_n is low, req_ready is all 0 and chk_busy is all 0.
- Arbitration latency: request to req_ready is 0 cycles (combinational). Transfer to rf_wr_enable is 1 cycle. Data is readable from the register file 2 cycles after the transfer.
- The scoreboard clears at the same edge the register file captures the data, so a read issued when chk_busy==0 sees the new value.
- Throughput: one write per cycle sustained. With all NR_REQ requesters valid continuously, each is granted once every NR_REQ cycles.
- Reset mid-operation: an in-flight output-stage write is dropped, and all busy bits clear.

## Configuration
- Macro TACHYON_RF_WB_BYPASS_EN.
- Defined: adds outputs byp_hit[NR_CHK] (1 bit) and byp_val[NR_CHK] (REG_WIDTH).
  - byp_hit[k] = rf_wr_enable & rf_wr_addr==chk_addr[k] & chk_addr[k]!=0.
  - byp_val[k] = rf_wr_val.
  - chk_busy[k] is forced to 0 when byp_hit[k] is high, so issue may proceed one cycle earlier using the forwarded value.
- Undefined: the ports are absent and chk_busy follows the scoreboard only.

## Structure
- Package tachyon_rf_pkg holds:
  - constants SIZE, ADDR_WIDTH, REG_WIDTH, NR_RD_PORTS;
  - typedefs rf_addr_t and rf_val_t;
  - struct wb_req_t {addr, val}.
- One sub-module: RrArbiter (parameter N; inputs req[N] and ptr; outputs grant[N], one-hot or zero, and grant_idx). It is purely combinational. rr_ptr lives in rf_wb_arbiter.

## Test plan
- After reset, with no stimulus: rf_wr_enable=0, sb_busy=0, and all req_ready=0 while rst_n=0.
- All three requesters valid for 6 cycles with addrs 1/2/3 -> grants in order 0,1,2,0,1,2. rf_wr_addr sequence is 1,2,3,1,2,3, each one cycle after its grant.
- Write to register 0 -> the request is accepted but rf_wr_enable stays 0. sb_set to register 0 -> sb_busy[0] stays 0.
- sb_set addr 7, then a requester writes addr 7 with 0xDEAD -> chk_busy for 7 is 1 until the edge where rf_wr_enable & addr==7, and 0 afterwards.
- sb_set addr 5 in the same cycle as rf_wr_enable addr 5 -> sb_busy[5]=1 after the edge.
- With TACHYON_RF_WB_BYPASS_EN defined: chk_addr=9 while the output stage holds addr 9 with val 0x1234 -> byp_hit=1, byp_val=0x1234, chk_busy=0.
- rst_n pulsed low while rf_wr_enable=1 -> outputs return to reset values immediately.
